// File: rtl/afe_readback_check.sv
// Post-configuration readback verifier: walks the command ROM, reads each listed AFE
// register over SPI (mode 0) and compares the returned value with the ROM's expected data.
module afe_readback_check #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int SCLK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [7:0]               rom_address,
    input  logic [ADDR_W+DATA_W-1:0] rom_entry,
    output logic                     sclk,
    output logic                     cs_n,
    output logic                     mosi,
    input  logic                     miso,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [7:0]               mismatch_count,
    output logic [ADDR_W-1:0]        first_fail_addr,
    output logic [DATA_W-1:0]        first_fail_data
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(2 * SCLK_DIV + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    localparam logic [7:0]       LAST_IDX  = 8'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] PHASE_END = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(2 * SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_W - 1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] ROM_REQ  = 4'd1;
    localparam logic [3:0] ROM_LAT  = 4'd2;
    localparam logic [3:0] CS_SETUP = 4'd3;
    localparam logic [3:0] SHIFT    = 4'd4;
    localparam logic [3:0] CS_HOLD  = 4'd5;
    localparam logic [3:0] COMPARE  = 4'd6;
    localparam logic [3:0] GAP      = 4'd7;
    localparam logic [3:0] FIN      = 4'd8;

    logic [3:0]         state_r;
    logic [7:0]         idx_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [BIT_W-1:0]   bit_r;
    logic [FRAME_W-1:0] frame_sr_r;
    logic [DATA_W-1:0]  rx_sr_r;
    logic [ADDR_W-1:0]  exp_addr_r;
    logic [DATA_W-1:0]  exp_data_r;
    logic [7:0]         rom_address_r;
    logic               sclk_r;
    logic               cs_n_r;
    logic               mosi_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [7:0]         mm_cnt_r;
    logic [ADDR_W-1:0]  ff_addr_r;
    logic [DATA_W-1:0]  ff_data_r;
    logic               mismatch_s;
    logic [DATA_W-1:0]  rx_next_s;

    // Read-vs-expected result and the miso shift-in value for the next rising edge.
    always_comb begin
        mismatch_s = (rx_sr_r != exp_data_r);
        rx_next_s  = {rx_sr_r[DATA_W-2:0], miso};
    end

    // Sequencer: ROM fetch, SPI read frame, compare and pass bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            idx_r         <= 8'd0;
            cnt_r         <= '0;
            bit_r         <= '0;
            frame_sr_r    <= '0;
            rx_sr_r       <= '0;
            exp_addr_r    <= '0;
            exp_data_r    <= '0;
            rom_address_r <= 8'd0;
            sclk_r        <= 1'b0;
            cs_n_r        <= 1'b1;
            mosi_r        <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            mm_cnt_r      <= 8'd0;
            ff_addr_r     <= '0;
            ff_data_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r       <= ROM_REQ;
                        idx_r         <= 8'd0;
                        rom_address_r <= 8'd0;
                        busy_r        <= 1'b1;
                        done_r        <= 1'b0;
                        pass_r        <= 1'b0;
                        mm_cnt_r      <= 8'd0;
                        ff_addr_r     <= '0;
                        ff_data_r     <= '0;
                    end
                end
                ROM_REQ: state_r <= ROM_LAT;
                ROM_LAT: begin
                    frame_sr_r <= {1'b1, rom_entry[ADDR_W+DATA_W-1:DATA_W], {DATA_W{1'b0}}};
                    exp_addr_r <= rom_entry[ADDR_W+DATA_W-1:DATA_W];
                    exp_data_r <= rom_entry[DATA_W-1:0];
                    cs_n_r     <= 1'b0;
                    mosi_r     <= 1'b1;
                    cnt_r      <= '0;
                    state_r    <= CS_SETUP;
                end
                CS_SETUP: begin
                    if (cnt_r == PHASE_END) begin
                        cnt_r   <= '0;
                        bit_r   <= '0;
                        sclk_r  <= 1'b1;
                        rx_sr_r <= rx_next_s;
                        state_r <= SHIFT;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    // Falling edge advances mosi; rising edge samples miso; the low phase
                    // after the last bit's falling edge ends the shift.
                    if (cnt_r == PHASE_END) begin
                        cnt_r <= '0;
                        if (sclk_r) begin
                            sclk_r     <= 1'b0;
                            mosi_r     <= frame_sr_r[FRAME_W-2];
                            frame_sr_r <= {frame_sr_r[FRAME_W-2:0], 1'b0};
                        end else if (bit_r == LAST_BIT) begin
                            state_r <= CS_HOLD;
                        end else begin
                            sclk_r  <= 1'b1;
                            bit_r   <= bit_r + BIT_W'(1);
                            rx_sr_r <= rx_next_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                CS_HOLD: begin
                    if (cnt_r == PHASE_END) begin
                        cnt_r   <= '0;
                        cs_n_r  <= 1'b1;
                        mosi_r  <= 1'b0;
                        state_r <= COMPARE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                COMPARE: begin
                    if (mismatch_s) begin
                        if (mm_cnt_r != 8'hFF) begin
                            mm_cnt_r <= mm_cnt_r + 8'd1;
                        end
                        if (mm_cnt_r == 8'd0) begin
                            ff_addr_r <= exp_addr_r;
                            ff_data_r <= rx_sr_r;
                        end
                    end
                    cnt_r <= '0;
                    if (idx_r == LAST_IDX) begin
                        state_r <= FIN;
                    end else begin
                        idx_r   <= idx_r + 8'd1;
                        state_r <= GAP;
                    end
                end
                GAP: begin
                    if (cnt_r == GAP_END) begin
                        cnt_r         <= '0;
                        rom_address_r <= idx_r;
                        state_r       <= ROM_REQ;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                FIN: begin
                    done_r  <= 1'b1;
                    pass_r  <= (mm_cnt_r == 8'd0);
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    cs_n_r  <= 1'b1;
                    sclk_r  <= 1'b0;
                    mosi_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_address     = rom_address_r;
    assign sclk            = sclk_r;
    assign cs_n            = cs_n_r;
    assign mosi            = mosi_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign mismatch_count  = mm_cnt_r;
    assign first_fail_addr = ff_addr_r;
    assign first_fail_data = ff_data_r;

endmodule
